// File: rtl/oq_merge_arbiter.sv
// Purpose: packet-granular weighted round-robin merge of the OQ-path and aggregator streams.
// Latency: one IDLE arbitration cycle per packet, then 0-cycle combinational data path.
// Backpressure: m_axis_tready goes straight to the granted input's tready; the loser is held at 0.
module oq_merge_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int OQ_WEIGHT          = 1,
  parameter int AGG_WEIGHT         = 1,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_oq_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_oq_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_oq_tuser,
  input  logic                            s_axis_oq_tvalid,
  input  logic                            s_axis_oq_tlast,
  output logic                            s_axis_oq_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
  input  logic                            s_axis_agg_tvalid,
  input  logic                            s_axis_agg_tlast,
  output logic                            s_axis_agg_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [1:0]                      grant,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_oq,
  output logic [CNT_WIDTH-1:0]            pkt_cnt_agg
);

  // Weight 0 behaves as 1; the burst counter is 4 bits so weights saturate at 15.
  localparam int OQ_W_I  = (OQ_WEIGHT  < 1) ? 1 : ((OQ_WEIGHT  > 15) ? 15 : OQ_WEIGHT);
  localparam int AGG_W_I = (AGG_WEIGHT < 1) ? 1 : ((AGG_WEIGHT > 15) ? 15 : AGG_WEIGHT);
  localparam logic [3:0] OQ_W  = 4'(OQ_W_I);
  localparam logic [3:0] AGG_W = 4'(AGG_W_I);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCK} state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;     // 0 = OQ, 1 = AGG
  logic       pref_q;           // 0 = OQ, 1 = AGG
  logic [3:0] burst_q;
  logic       pkt_done;
  logic [3:0] pref_w;

  assign pref_w = pref_q ? AGG_W : OQ_W;

  // Arbitration: pick an input only in IDLE, release LOCK after the tlast beat transfers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pref_q ? s_axis_agg_tvalid : s_axis_oq_tvalid) begin
          sel_d   = pref_q;
          state_d = LOCK;
        end else if (pref_q ? s_axis_oq_tvalid : s_axis_agg_tvalid) begin
          sel_d   = ~pref_q;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (pkt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux and ready steering; everything is forced low outside LOCK.
  always_comb begin
    m_axis_tdata      = '0;
    m_axis_tkeep      = '0;
    m_axis_tuser      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    s_axis_oq_tready  = 1'b0;
    s_axis_agg_tready = 1'b0;
    grant             = 2'b00;
    if (state_q == LOCK) begin
      if (sel_q) begin
        m_axis_tdata      = s_axis_agg_tdata;
        m_axis_tkeep      = s_axis_agg_tkeep;
        m_axis_tuser      = s_axis_agg_tuser;
        m_axis_tvalid     = s_axis_agg_tvalid;
        m_axis_tlast      = s_axis_agg_tlast;
        s_axis_agg_tready = m_axis_tready;
        grant             = 2'b10;
      end else begin
        m_axis_tdata      = s_axis_oq_tdata;
        m_axis_tkeep      = s_axis_oq_tkeep;
        m_axis_tuser      = s_axis_oq_tuser;
        m_axis_tvalid     = s_axis_oq_tvalid;
        m_axis_tlast      = s_axis_oq_tlast;
        s_axis_oq_tready  = m_axis_tready;
        grant             = 2'b01;
      end
    end
  end

  assign pkt_done = (state_q == LOCK) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Control state, weighted turn tracking and per-input packet counters.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      pref_q      <= 1'b0;
      burst_q     <= 4'd0;
      pkt_cnt_oq  <= '0;
      pkt_cnt_agg <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (pkt_done) begin
        // A packet granted to the non-preferred input (pref was idle) does not use up pref's turn.
        if (sel_q == pref_q) begin
          if ((burst_q + 4'd1) == pref_w) begin
            pref_q  <= ~pref_q;
            burst_q <= 4'd0;
          end else begin
            burst_q <= burst_q + 4'd1;
          end
        end
        if (sel_q) pkt_cnt_agg <= pkt_cnt_agg + CNT_ONE;
        else       pkt_cnt_oq  <= pkt_cnt_oq + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_oq_merge_arbiter.sv
// Purpose: directed self-checking bench for oq_merge_arbiter (three instances: weights 1/1, AGG 3 with 4-bit counters, AGG 0).
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: m_axis_tready is driven by the bench per scenario.
module tb_oq_merge_arbiter;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int TU = 16;
  localparam logic [DW-1:0] OQD = 64'h0123_4567_89AB_CD11;
  localparam logic [DW-1:0] AGD = 64'hFEDC_BA98_7654_3222;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] oq_tdata, agg_tdata;
  logic [KW-1:0] oq_tkeep, agg_tkeep;
  logic [TU-1:0] oq_tuser, agg_tuser;
  logic oq_tvalid, oq_tlast, agg_tvalid, agg_tlast, m_tready;

  logic [DW-1:0] m_tdata [3];
  logic [KW-1:0] m_tkeep [3];
  logic [TU-1:0] m_tuser [3];
  logic m_tvalid [3];
  logic m_tlast [3];
  logic oq_tready [3];
  logic agg_tready [3];
  logic [1:0] grant [3];
  logic [31:0] a_cnt_oq, a_cnt_agg, c_cnt_oq, c_cnt_agg;
  logic [3:0] b_cnt_oq, b_cnt_agg;

  always #5 clk = ~clk;

  oq_merge_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .OQ_WEIGHT(1), .AGG_WEIGHT(1), .CNT_WIDTH(32)) dut_a (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_oq_tdata(oq_tdata), .s_axis_oq_tkeep(oq_tkeep), .s_axis_oq_tuser(oq_tuser),
    .s_axis_oq_tvalid(oq_tvalid), .s_axis_oq_tlast(oq_tlast), .s_axis_oq_tready(oq_tready[0]),
    .s_axis_agg_tdata(agg_tdata), .s_axis_agg_tkeep(agg_tkeep), .s_axis_agg_tuser(agg_tuser),
    .s_axis_agg_tvalid(agg_tvalid), .s_axis_agg_tlast(agg_tlast), .s_axis_agg_tready(agg_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tuser(m_tuser[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready),
    .grant(grant[0]), .pkt_cnt_oq(a_cnt_oq), .pkt_cnt_agg(a_cnt_agg));

  oq_merge_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .OQ_WEIGHT(1), .AGG_WEIGHT(3), .CNT_WIDTH(4)) dut_b (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_oq_tdata(oq_tdata), .s_axis_oq_tkeep(oq_tkeep), .s_axis_oq_tuser(oq_tuser),
    .s_axis_oq_tvalid(oq_tvalid), .s_axis_oq_tlast(oq_tlast), .s_axis_oq_tready(oq_tready[1]),
    .s_axis_agg_tdata(agg_tdata), .s_axis_agg_tkeep(agg_tkeep), .s_axis_agg_tuser(agg_tuser),
    .s_axis_agg_tvalid(agg_tvalid), .s_axis_agg_tlast(agg_tlast), .s_axis_agg_tready(agg_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tuser(m_tuser[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready),
    .grant(grant[1]), .pkt_cnt_oq(b_cnt_oq), .pkt_cnt_agg(b_cnt_agg));

  oq_merge_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .OQ_WEIGHT(1), .AGG_WEIGHT(0), .CNT_WIDTH(32)) dut_c (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_oq_tdata(oq_tdata), .s_axis_oq_tkeep(oq_tkeep), .s_axis_oq_tuser(oq_tuser),
    .s_axis_oq_tvalid(oq_tvalid), .s_axis_oq_tlast(oq_tlast), .s_axis_oq_tready(oq_tready[2]),
    .s_axis_agg_tdata(agg_tdata), .s_axis_agg_tkeep(agg_tkeep), .s_axis_agg_tuser(agg_tuser),
    .s_axis_agg_tvalid(agg_tvalid), .s_axis_agg_tlast(agg_tlast), .s_axis_agg_tready(agg_tready[2]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tkeep(m_tkeep[2]), .m_axis_tuser(m_tuser[2]),
    .m_axis_tvalid(m_tvalid[2]), .m_axis_tlast(m_tlast[2]), .m_axis_tready(m_tready),
    .grant(grant[2]), .pkt_cnt_oq(c_cnt_oq), .pkt_cnt_agg(c_cnt_agg));

  // tkeep/tuser are derived from tdata so every beat carries distinct sidebands.
  task automatic drv_oq(input logic v, input logic [DW-1:0] d, input logic l);
    oq_tvalid = v; oq_tdata = d; oq_tlast = l;
    oq_tkeep = ~d[KW-1:0]; oq_tuser = {d[7:0], ~d[15:8]};
  endtask

  task automatic drv_agg(input logic v, input logic [DW-1:0] d, input logic l);
    agg_tvalid = v; agg_tdata = d; agg_tlast = l;
    agg_tkeep = ~d[KW-1:0]; agg_tuser = {d[7:0], ~d[15:8]};
  endtask

  task automatic apply_reset;
    @(negedge clk);
    #3 rst_n = 1'b0;
    drv_oq(1'b0, '0, 1'b0); drv_agg(1'b0, '0, 1'b0); m_tready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; m_tready = 1'b1;
    drv_oq(1'b1, OQD, 1'b1); drv_agg(1'b1, AGD, 1'b1);
    @(negedge clk); @(negedge clk); #1;
    checks++; if (m_tvalid[0] !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%0h exp=0", m_tvalid[0]); end
    checks++; if (m_tlast[0] !== 1'b0) begin failures++; $display("FAIL reset_m_tlast got=%0h exp=0", m_tlast[0]); end
    checks++; if (oq_tready[0] !== 1'b0) begin failures++; $display("FAIL reset_oq_tready got=%0h exp=0", oq_tready[0]); end
    checks++; if (agg_tready[0] !== 1'b0) begin failures++; $display("FAIL reset_agg_tready got=%0h exp=0", agg_tready[0]); end
    checks++; if (grant[0] !== 2'b00) begin failures++; $display("FAIL reset_grant got=%0h exp=0", grant[0]); end
    checks++; if (a_cnt_oq !== 32'd0 || a_cnt_agg !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", a_cnt_oq, a_cnt_agg); end
    drv_oq(1'b0, '0, 1'b0); drv_agg(1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_oq;
    logic [DW-1:0] d;
    @(negedge clk);
    drv_oq(1'b1, OQD, 1'b0); #1;
    checks++; if (grant[0] !== 2'b00 || m_tvalid[0] !== 1'b0 || oq_tready[0] !== 1'b0) begin
      failures++; $display("FAIL single_idle got=grant%0h/v%0h/r%0h exp=0/0/0", grant[0], m_tvalid[0], oq_tready[0]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = OQD + DW'(i * 16'h0101);
      drv_oq(1'b1, d, i == 2); #1;
      checks++; if (grant[0] !== 2'b01) begin failures++; $display("FAIL single_grant beat%0d got=%0h exp=1", i, grant[0]); end
      checks++; if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== d) begin failures++; $display("FAIL single_data beat%0d got=%0h exp=%0h", i, m_tdata[0], d); end
      checks++; if (m_tkeep[0] !== ~d[KW-1:0] || m_tuser[0] !== {d[7:0], ~d[15:8]}) begin
        failures++; $display("FAIL single_side beat%0d got=%0h/%0h exp=%0h/%0h", i, m_tkeep[0], m_tuser[0], ~d[KW-1:0], {d[7:0], ~d[15:8]}); end
      checks++; if (m_tlast[0] !== (i == 2)) begin failures++; $display("FAIL single_tlast beat%0d got=%0h exp=%0h", i, m_tlast[0], i == 2); end
      checks++; if (oq_tready[0] !== 1'b1 || agg_tready[0] !== 1'b0) begin
        failures++; $display("FAIL single_tready beat%0d got=%0h/%0h exp=1/0", i, oq_tready[0], agg_tready[0]); end
    end
    @(negedge clk);
    drv_oq(1'b0, '0, 1'b0); #1;
    checks++; if (grant[0] !== 2'b00 || m_tvalid[0] !== 1'b0) begin failures++; $display("FAIL single_end got=%0h/%0h exp=0/0", grant[0], m_tvalid[0]); end
    checks++; if (a_cnt_oq !== 32'd1 || a_cnt_agg !== 32'd0) begin failures++; $display("FAIL single_cnt got=%0d/%0d exp=1/0", a_cnt_oq, a_cnt_agg); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_a, exp_b;
    int p;
    apply_reset;
    drv_oq(1'b1, OQD, 1'b1); drv_agg(1'b1, AGD, 1'b1); m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      p = k / 2;
      exp_a = (k % 2 == 0) ? 2'b00 : ((p % 2 == 0) ? 2'b01 : 2'b10);
      exp_b = (k % 2 == 0) ? 2'b00 : ((p % 4 == 0) ? 2'b01 : 2'b10);
      checks++; if (grant[0] !== exp_a) begin failures++; $display("FAIL rr11_grant cyc%0d got=%0h exp=%0h", k, grant[0], exp_a); end
      checks++; if (grant[1] !== exp_b) begin failures++; $display("FAIL rr_w3_grant cyc%0d got=%0h exp=%0h", k, grant[1], exp_b); end
      checks++; if (grant[2] !== exp_a) begin failures++; $display("FAIL rr_w0_grant cyc%0d got=%0h exp=%0h", k, grant[2], exp_a); end
      if (k == 3) begin
        checks++; if (m_tdata[0] !== AGD) begin failures++; $display("FAIL rr_agg_data got=%0h exp=%0h", m_tdata[0], AGD); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (a_cnt_oq !== 32'd4 || a_cnt_agg !== 32'd4) begin failures++; $display("FAIL rr11_cnt got=%0d/%0d exp=4/4", a_cnt_oq, a_cnt_agg); end
    checks++; if (b_cnt_oq !== 4'd2 || b_cnt_agg !== 4'd6) begin failures++; $display("FAIL rr_w3_cnt got=%0d/%0d exp=2/6", b_cnt_oq, b_cnt_agg); end
    checks++; if (c_cnt_oq !== 32'd4 || c_cnt_agg !== 32'd4) begin failures++; $display("FAIL rr_w0_cnt got=%0d/%0d exp=4/4", c_cnt_oq, c_cnt_agg); end
    drv_oq(1'b0, '0, 1'b0); drv_agg(1'b0, '0, 1'b0);
  endtask

  task automatic test_backpressure;
    apply_reset;
    m_tready = 1'b1;
    drv_agg(1'b1, AGD, 1'b0); #1;
    checks++; if (grant[0] !== 2'b00) begin failures++; $display("FAIL bp_idle_grant got=%0h exp=0", grant[0]); end
    @(negedge clk);
    drv_oq(1'b1, OQD, 1'b1); #1;
    checks++; if (grant[0] !== 2'b10 || m_tdata[0] !== AGD) begin failures++; $display("FAIL bp_beat1 got=%0h/%0h exp=2/%0h", grant[0], m_tdata[0], AGD); end
    checks++; if (oq_tready[0] !== 1'b0 || agg_tready[0] !== 1'b1) begin failures++; $display("FAIL bp_beat1_rdy got=%0h/%0h exp=0/1", oq_tready[0], agg_tready[0]); end
    @(negedge clk);
    drv_agg(1'b1, AGD + 64'd1, 1'b0); #1;
    checks++; if (m_tdata[0] !== AGD + 64'd1) begin failures++; $display("FAIL bp_beat2 got=%0h exp=%0h", m_tdata[0], AGD + 64'd1); end
    @(negedge clk);
    drv_agg(1'b1, AGD + 64'd2, 1'b0); m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== AGD + 64'd2 || grant[0] !== 2'b10) begin
        failures++; $display("FAIL bp_hold cyc%0d got=v%0h/%0h/g%0h exp=v1/%0h/g2", k, m_tvalid[0], m_tdata[0], grant[0], AGD + 64'd2); end
      checks++; if (oq_tready[0] !== 1'b0 || agg_tready[0] !== 1'b0) begin
        failures++; $display("FAIL bp_hold_rdy cyc%0d got=%0h/%0h exp=0/0", k, oq_tready[0], agg_tready[0]); end
      @(negedge clk);
    end
    m_tready = 1'b1; #1;
    checks++; if (m_tdata[0] !== AGD + 64'd2 || agg_tready[0] !== 1'b1) begin
      failures++; $display("FAIL bp_release got=%0h/%0h exp=%0h/1", m_tdata[0], agg_tready[0], AGD + 64'd2); end
    @(negedge clk);
    drv_agg(1'b1, AGD + 64'd3, 1'b1); #1;
    checks++; if (m_tlast[0] !== 1'b1 || grant[0] !== 2'b10 || oq_tready[0] !== 1'b0) begin
      failures++; $display("FAIL bp_last got=l%0h/g%0h/r%0h exp=l1/g2/r0", m_tlast[0], grant[0], oq_tready[0]); end
    @(negedge clk);
    drv_agg(1'b0, '0, 1'b0); #1;
    checks++; if (grant[0] !== 2'b00 || m_tvalid[0] !== 1'b0 || oq_tready[0] !== 1'b0) begin
      failures++; $display("FAIL bp_gap got=g%0h/v%0h/r%0h exp=0/0/0", grant[0], m_tvalid[0], oq_tready[0]); end
    @(negedge clk); #1;
    checks++; if (grant[0] !== 2'b01 || m_tdata[0] !== OQD || oq_tready[0] !== 1'b1) begin
      failures++; $display("FAIL bp_oq_next got=g%0h/%0h/r%0h exp=g1/%0h/r1", grant[0], m_tdata[0], oq_tready[0], OQD); end
    @(negedge clk);
    drv_oq(1'b0, '0, 1'b0); #1;
    checks++; if (a_cnt_oq !== 32'd1 || a_cnt_agg !== 32'd1) begin failures++; $display("FAIL bp_cnt got=%0d/%0d exp=1/1", a_cnt_oq, a_cnt_agg); end
  endtask

  task automatic test_reset_mid_packet;
    // Follows test_backpressure: counters are 1/1 and pref points at AGG.
    @(negedge clk);
    drv_oq(1'b1, OQD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drv_oq(1'b1, OQD + 64'd5, 1'b0); drv_agg(1'b1, AGD, 1'b1); #1;
    checks++; if (grant[0] !== 2'b01 || oq_tready[0] !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0h/%0h exp=1/1", grant[0], oq_tready[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid[0] !== 1'b0 || grant[0] !== 2'b00) begin failures++; $display("FAIL rmid_async got=v%0h/g%0h exp=0/0", m_tvalid[0], grant[0]); end
    checks++; if (oq_tready[0] !== 1'b0 || agg_tready[0] !== 1'b0) begin failures++; $display("FAIL rmid_rdy got=%0h/%0h exp=0/0", oq_tready[0], agg_tready[0]); end
    checks++; if (a_cnt_oq !== 32'd0 || a_cnt_agg !== 32'd0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", a_cnt_oq, a_cnt_agg); end
    @(negedge clk);
    rst_n = 1'b1;
    drv_oq(1'b1, OQD, 1'b1); #1;
    checks++; if (grant[0] !== 2'b00) begin failures++; $display("FAIL rmid_idle got=%0h exp=0", grant[0]); end
    @(negedge clk); #1;
    checks++; if (grant[0] !== 2'b01 || m_tdata[0] !== OQD) begin failures++; $display("FAIL rmid_first got=%0h/%0h exp=1/%0h", grant[0], m_tdata[0], OQD); end
    @(negedge clk);
    drv_oq(1'b0, '0, 1'b0); drv_agg(1'b0, '0, 1'b0);
  endtask

  task automatic test_counter_wrap;
    apply_reset;
    drv_oq(1'b1, OQD, 1'b1); m_tready = 1'b1;
    for (int k = 0; k < 32; k++) @(negedge clk);
    #1;
    checks++; if (b_cnt_oq !== 4'd0 || a_cnt_oq !== 32'd16) begin failures++; $display("FAIL wrap16 got=%0d/%0d exp=0/16", b_cnt_oq, a_cnt_oq); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (b_cnt_oq !== 4'd1 || a_cnt_oq !== 32'd17) begin failures++; $display("FAIL wrap17 got=%0d/%0d exp=1/17", b_cnt_oq, a_cnt_oq); end
    checks++; if (b_cnt_agg !== 4'd0) begin failures++; $display("FAIL wrap_agg got=%0d exp=0", b_cnt_agg); end
    drv_oq(1'b0, '0, 1'b0);
  endtask

  initial begin
    drv_oq(1'b0, '0, 1'b0); drv_agg(1'b0, '0, 1'b0); m_tready = 1'b1;
    test_reset;
    test_single_oq;
    test_round_robin;
    test_backpressure;
    test_reset_mid_packet;
    test_counter_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oq_merge_arbiter.md
# oq_merge_arbiter

- Packet-granular, weighted round-robin arbiter that merges the parser's non-aggregation stream (OQ path) and the aggregation pipeline's result stream into the single AXI-Stream feeding the output queues.
- Sits after the parser and the aggregator, in front of the output queues.
- Never interleaves beats of different packets.
- Keeps per-input packet counters for statistics.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width on all ports.
- C_AXIS_TUSER_WIDTH, 128, tuser width on all ports.
- OQ_WEIGHT, 1, consecutive packets the OQ input may send while the AGG input waits; 0 is treated as 1.
- AGG_WEIGHT, 1, the same quantity for the AGG input; 0 is treated as 1.
- CNT_WIDTH, 32, width of the packet counters.

Ports:
- axis_aclk  in  1  single clock.
- axis_resetn  in  1  reset, asynchronous, active-low.
- s_axis_oq_tdata/tkeep/tuser/tvalid/tlast  in  W/W/8/TU/1/1  OQ-path input from the parser.
- s_axis_oq_tready  out  1  ready for the OQ-path input.
- s_axis_agg_tdata/tkeep/tuser/tvalid/tlast  in  W/W/8/TU/1/1  aggregator result input.
- s_axis_agg_tready  out  1  ready for the aggregator input.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  W/W/8/TU/1/1  merged stream to the output queues.
- m_axis_tready  in  1  ready from the output queues.
- grant  out  2  one-hot active grant: bit0 = OQ, bit1 = AGG; 00 when idle.
- pkt_cnt_oq  out  CNT_WIDTH  packets forwarded from the OQ input.
- pkt_cnt_agg  out  CNT_WIDTH  packets forwarded from the AGG input.

## Operation
State machine: IDLE, LOCK.

Registers:
- sel: granted input.
- pref: preferred input, 0 = OQ, 1 = AGG.
- burst_cnt: 4 bits, packets sent by pref in the current turn.

IDLE:
- Both s_*_tready = 0; m_axis_tvalid = 0; grant = 00.
- If the pref input has tvalid = 1: sel = pref, go to LOCK.
- Else if the other input has tvalid = 1: sel = other, go to LOCK.
- Else stay in IDLE.

LOCK:
- m_axis_* is muxed combinationally from input sel: m_axis_tvalid = sel tvalid.
- s_sel_tready = m_axis_tready; the non-selected tready = 0.
- grant = onehot(sel).
- On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: the packet completes; go to IDLE next cycle.

Weight update, applied at packet completion:
- If sel == pref: burst_cnt + 1 == weight(pref) → pref flips and burst_cnt = 0; otherwise burst_cnt increments.
- If sel != pref (pref was idle at grant time): pref and burst_cnt are unchanged.

Counters:
- pkt_cnt_oq or pkt_cnt_agg increments by 1 on each packet completion for the corresponding sel.
- Counters wrap modulo 2^CNT_WIDTH and are cleared only by reset.

Other rules:
- Input data is never modified or buffered; the block adds no storage beyond control state.
- Reset (asynchronous, any time, including mid-packet): state = IDLE, pref = OQ, burst_cnt = 0, counters = 0.
  - All outputs drop to 0 immediately: tready, m_axis_tvalid, grant.
  - A packet interrupted mid-flight is truncated; upstream and downstream are reset together.

## Timing
- Reset values: s_axis_oq_tready = 0, s_axis_agg_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, grant = 00, pkt_cnt_* = 0.
  - m_axis_tdata/tkeep/tuser are don't-care while m_axis_tvalid = 0; they are driven 0 in IDLE.
- Arbitration costs exactly one IDLE cycle per packet; there is no bypass from IDLE.
- A 1-beat packet occupies 2 cycles minimum; an N-beat packet occupies N+1 cycles minimum.
- Data path latency within LOCK is 0 cycles, input to output combinational.
- tready path: m_axis_tready → s_sel_tready is combinational. There is no combinational path from any tvalid to any tready.
- Arbitration samples tvalid in IDLE only. A request arriving during LOCK waits for the next IDLE cycle.
- Simultaneous requests in IDLE: pref wins.
- Backpressure (m_axis_tready = 0) in LOCK:
  - The beat is held by the upstream.
  - The grant does not change.
  - The other input stays blocked.
- A granted input may drop tvalid mid-packet (bubble). The grant holds until tlast is transferred.
- Counters, pref and burst_cnt update on the clock edge of the completing beat.

## Test plan
- Single OQ packet, 3 beats, AGG idle, m_axis_tready = 1:
  - 1 IDLE cycle, then the 3 beats appear on m_axis with identical tdata/tkeep/tuser.
  - grant = 01 for 3 cycles; pkt_cnt_oq = 1; pkt_cnt_agg = 0.
- Both inputs continuously valid with 1-beat packets, weights 1/1:
  - Output order is OQ, AGG, OQ, AGG; one packet every 2 cycles.
  - After 8 packets, pkt_cnt_oq = pkt_cnt_agg = 4.
- Both saturated, AGG_WEIGHT = 3, OQ_WEIGHT = 1:
  - Order is OQ, AGG, AGG, AGG, OQ, AGG.
  - With AGG_WEIGHT = 0, behaviour is identical to weight 1.
- Backpressure mid-packet:
  - AGG 4-beat packet granted; m_axis_tready = 0 for 5 cycles after beat 2; OQ valid throughout.
  - Beat 3 is held stable, s_axis_oq_tready stays 0, and no OQ beat is interleaved.
  - OQ is granted only after AGG's tlast is transferred plus 1 IDLE cycle.
- Reset mid-packet: assert axis_resetn = 0 during beat 2 of an OQ packet, asynchronously to the clock edge.
  - m_axis_tvalid, both tready and grant go to 0 without waiting for a clock edge.
  - Counters read 0.
  - After release with both inputs valid, OQ is granted first.
- Counter wrap, CNT_WIDTH = 4: 17 OQ packets → pkt_cnt_oq = 1.
